// File: rtl/instr_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, reads instruction memory over req/ack,
// and feeds the IF/ID buffer through an output slot backed by a one-entry skid register.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_FETCH | request outstanding at pc; ack fills output slot or skid
// S_SKID  | skid holds a word the stalled output could not take; no request
// S_DRAIN | finish the read abandoned by a redirect; its data is dropped
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] fetch_pc,
  output logic [31:0] pc_plus4,
  output logic        valid
);

  typedef enum logic [1:0] {S_FETCH, S_SKID, S_DRAIN} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic [31:0] drain_addr;
  logic        slot_free;

  assign pc_next   = pc + 32'd4;
  assign slot_free = !valid || !stall;
  assign imem_req  = (state != S_SKID);
  // The abandoned read keeps its address until memory acknowledges it.
  assign imem_addr = (state == S_DRAIN) ? drain_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= {RESET_PC[31:2], 2'b00};
      valid      <= 1'b0;
      instr      <= 32'd0;
      fetch_pc   <= 32'd0;
      pc_plus4   <= 32'd0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      drain_addr <= 32'd0;
    end else if (redirect) begin
      valid      <= 1'b0;
      skid_instr <= 32'd0;
      skid_pc    <= 32'd0;
      pc         <= {redirect_pc[31:2], 2'b00};
      case (state)
        S_FETCH: begin
          if (!imem_ack) begin
            state      <= S_DRAIN;
            drain_addr <= pc;
          end
        end
        S_SKID:  state <= S_FETCH;
        default: state <= S_DRAIN;
      endcase
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            pc <= pc_next;
            if (slot_free) begin
              valid    <= 1'b1;
              instr    <= imem_rdata;
              fetch_pc <= pc;
              pc_plus4 <= pc_next;
            end else begin
              skid_instr <= imem_rdata;
              skid_pc    <= pc;
              state      <= S_SKID;
            end
          end else if (!stall) begin
            valid <= 1'b0;
          end
        end
        S_SKID: begin
          if (!stall) begin
            valid    <= 1'b1;
            instr    <= skid_instr;
            fetch_pc <= skid_pc;
            pc_plus4 <= skid_pc + 32'd4;
            state    <= S_FETCH;
          end
        end
        S_DRAIN: begin
          if (imem_ack) state <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against an in-order consumed-PC stream model and a latency-driven memory.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] fetch_pc;
  logic [31:0] pc_plus4;
  logic        valid;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_fetch_pc;
  logic [31:0] w_pc_plus4;
  logic        w_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [31:0] exp_pc;
  int          consumed;
  int          lat;
  int          wcnt;
  logic        hold_pend, flush_pend, addr_pend;
  logic [31:0] snap_instr, snap_pc, snap_p4, snap_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign w_rdata = mem_word(w_addr);

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr(instr), .fetch_pc(fetch_pc), .pc_plus4(pc_plus4), .valid(valid)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ack(1'b1), .imem_rdata(w_rdata),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .instr(w_instr), .fetch_pc(w_fetch_pc), .pc_plus4(w_pc_plus4), .valid(w_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout, expected summary before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    hold_pend = 1'b0; flush_pend = 1'b0; addr_pend = 1'b0;
    wcnt = 0; exp_pc = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_fetch_pc", fetch_pc, 32'd0);
    chk("rst_pc_plus4", pc_plus4, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'd0);
    rst_n = 1'b1;
  endtask

  // One clock cycle: called at a falling edge, leaves at the next falling edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    logic ack;
    chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
    if (hold_pend) begin
      chk("hold_valid", {31'd0, valid}, 32'd1);
      chk("hold_instr", instr, snap_instr);
      chk("hold_fetch_pc", fetch_pc, snap_pc);
      chk("hold_pc_plus4", pc_plus4, snap_p4);
    end
    if (flush_pend) chk("flush_valid", {31'd0, valid}, 32'd0);
    if (addr_pend) begin
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, snap_addr);
    end
    ack = imem_req && (wcnt + 1 >= lat);
    stall = st; redirect = rd; redirect_pc = rpc; imem_ack = ack;
    imem_rdata = ack ? mem_word(imem_addr) : $urandom;
    if (valid && !st && !rd) begin
      chk("stream_fetch_pc", fetch_pc, exp_pc);
      chk("stream_pc_plus4", pc_plus4, exp_pc + 32'd4);
      chk("stream_instr", instr, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    if (rd) exp_pc = rpc;
    hold_pend  = valid && st && !rd;
    snap_instr = instr; snap_pc = fetch_pc; snap_p4 = pc_plus4;
    flush_pend = rd;
    addr_pend  = imem_req && !ack;
    snap_addr  = imem_addr;
    if (imem_req) wcnt = ack ? 0 : wcnt + 1;
    @(negedge clk);
  endtask

  initial begin
    int   nv;
    logic found;
    logic st, rd;
    logic [31:0] rpc;
    consumed = 0;
    lat = 1;

    // ack tied high, no stall; wrap instance runs alongside
    do_reset();
    step(0, 0, 0);
    chk("first_valid", {31'd0, valid}, 32'd1);
    chk("first_fetch_pc", fetch_pc, 32'h0);
    chk("first_pc_plus4", pc_plus4, 32'h4);
    chk("wrap0_fetch_pc", w_fetch_pc, 32'hFFFF_FFF8);
    chk("wrap0_pc_plus4", w_pc_plus4, 32'hFFFF_FFFC);
    chk("wrap0_instr", w_instr, mem_word(32'hFFFF_FFF8));
    step(0, 0, 0);
    chk("second_fetch_pc", fetch_pc, 32'h4);
    chk("wrap1_fetch_pc", w_fetch_pc, 32'hFFFF_FFFC);
    chk("wrap1_pc_plus4", w_pc_plus4, 32'h0);
    step(0, 0, 0);
    chk("third_fetch_pc", fetch_pc, 32'h8);
    chk("third_pc_plus4", pc_plus4, 32'hC);
    chk("wrap2_fetch_pc", w_fetch_pc, 32'h0);
    chk("wrap2_valid", {31'd0, w_valid}, 32'd1);
    chk("wrap2_req", {31'd0, w_req}, 32'd1);
    step(0, 0, 0);

    // 3-cycle memory latency
    do_reset();
    lat = 3;
    nv = 0;
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      if (valid) nv++;
    end
    chk("lat3_valid_pulses", nv, 32'd4);
    step(0, 0, 0);

    // stall for 4 cycles while an ack lands in the skid
    do_reset();
    lat = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    chk("pre_stall_fetch_pc", fetch_pc, 32'h4);
    step(1, 0, 0);
    chk("skid_no_req", {31'd0, imem_req}, 32'd0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("skid_held_pc", fetch_pc, 32'h4);
    step(0, 0, 0);
    chk("skid_out_pc", fetch_pc, 32'h8);
    chk("skid_out_instr", instr, mem_word(32'h8));
    chk("skid_refetch_req", {31'd0, imem_req}, 32'd1);
    chk("skid_refetch_addr", imem_addr, 32'hC);
    step(0, 0, 0);
    step(0, 0, 0);

    // redirect while a 2-cycle read of 0x10 is pending
    do_reset();
    lat = 2;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (imem_req && imem_addr == 32'h10 && wcnt == 0) found = 1'b1;
      else step(0, 0, 0);
    end
    chk("drain_reached", {31'd0, found}, 32'd1);
    step(0, 1, 32'h100);
    chk("drain_addr", imem_addr, 32'h10);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    step(0, 0, 0);
    chk("after_drain_addr", imem_addr, 32'h100);
    for (int i = 0; i < 10 && !valid; i++) step(0, 0, 0);
    chk("redir_first_pc", fetch_pc, 32'h100);
    chk("redir_first_instr", instr, mem_word(32'h100));
    step(0, 0, 0);

    // redirect coincident with ack and stall, then redirect from skid
    do_reset();
    lat = 1;
    step(0, 0, 0);
    step(1, 1, 32'h200);
    chk("flush_stall_valid", {31'd0, valid}, 32'd0);
    chk("flush_stall_addr", imem_addr, 32'h200);
    step(0, 0, 0);
    chk("flush_next_pc", fetch_pc, 32'h200);
    step(1, 0, 0);
    chk("skid_state_req", {31'd0, imem_req}, 32'd0);
    step(1, 1, 32'h300);
    chk("skid_redir_valid", {31'd0, valid}, 32'd0);
    chk("skid_redir_addr", imem_addr, 32'h300);
    chk("skid_redir_req", {31'd0, imem_req}, 32'd1);
    step(0, 0, 0);
    chk("skid_redir_pc", fetch_pc, 32'h300);
    step(0, 0, 0);

    // randomized traffic
    do_reset();
    consumed = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) lat = $urandom_range(1, 4);
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + {28'd0, 2'($urandom_range(0, 3)), 2'b00};
      else rpc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      step(st, rd, rpc);
    end
    chk("random_progress", {31'd0, (consumed >= 100)}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
